i2c_line_cond: RTL and testbench



---
 rtl/i2c_cond_pkg.sv | 16 +
 rtl/i2c_glitch_filter.sv | 44 ++++
 rtl/i2c_line_cond.sv | 96 +++++++++
 tb/tb_i2c_line_cond.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cond_pkg.sv
// Shared constants and types for the I2C pad-input conditioning stage.
// Used by i2c_glitch_filter and i2c_line_cond.
package i2c_cond_pkg;

  localparam int unsigned FILT_LEN_DEF  = 4;
  localparam int unsigned STUCK_CYC_DEF = 100000;
  localparam int unsigned FILT_CW       = 4;
  localparam int unsigned STUCK_CW      = 24;

  // One sample of the two bus lines.
  typedef struct packed {
    logic scl;
    logic sda;
  } i2c_lines_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter.
// The output follows the input only after FILT_LEN consecutive differing samples.
module i2c_glitch_filter
  import i2c_cond_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic d_i,
  output logic q_o
);

  localparam logic [FILT_CW-1:0] CNT_LAST = FILT_CW'(FILT_LEN - 1);

  generate
    if (FILT_LEN == 0 || FILT_LEN > 15) begin : g_bad_filt_len
      $error("i2c_glitch_filter: FILT_LEN must be in 1..15");
    end
  endgenerate

  logic [1:0]         sync_q;
  logic [FILT_CW-1:0] cnt_q;

  // Idle bus is high, so everything resets to 1 and no edge is seen on release.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      q_o    <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], d_i};
      if (sync_q[1] == q_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        q_o   <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + FILT_CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: filtering, START/STOP detection, bus-busy tracking.
// Define I2C_STUCK_DET_EN to build the SCL-stuck-low detector; otherwise scl_stuck is 0.
module i2c_line_cond
  import i2c_cond_pkg::*;
#(
  parameter int unsigned FILT_LEN  = FILT_LEN_DEF,
  parameter int unsigned STUCK_CYC = STUCK_CYC_DEF
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic scl_pad_i,
  input  logic sda_pad_i,
  output logic scl_i,
  output logic sda_i,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic scl_stuck
);

  generate
    if (STUCK_CYC == 0 || STUCK_CYC > 32'h00FF_FFFF) begin : g_bad_stuck_cyc
      $error("i2c_line_cond: STUCK_CYC must be in 1..2^24-1");
    end
  endgenerate

  i2c_lines_t prev_q;
  logic       start_c;
  logic       stop_c;

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .d_i     (scl_pad_i),
    .q_o     (scl_i)
  );

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .d_i     (sda_pad_i),
    .q_o     (sda_i)
  );

  // SCL must be high before and after the SDA edge, so simultaneous edges never qualify.
  assign start_c = prev_q.scl & scl_i &  prev_q.sda & ~sda_i;
  assign stop_c  = prev_q.scl & scl_i & ~prev_q.sda &  sda_i;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prev_q    <= '{scl: 1'b1, sda: 1'b1};
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      prev_q    <= '{scl: scl_i, sda: sda_i};
      start_det <= start_c;
      stop_det  <= stop_c;
      if (start_c) begin
        bus_busy <= 1'b1;
      end else if (stop_c) begin
        bus_busy <= 1'b0;
      end
    end
  end

`ifdef I2C_STUCK_DET_EN
  localparam logic [STUCK_CW-1:0] STUCK_MAX = STUCK_CW'(STUCK_CYC);

  logic [STUCK_CW-1:0] stuck_cnt_q;
  logic [STUCK_CW-1:0] stuck_cnt_d;

  // Saturating count of consecutive filtered-SCL-low cycles.
  always_comb begin
    stuck_cnt_d = stuck_cnt_q;
    if (scl_i) begin
      stuck_cnt_d = '0;
    end else if (stuck_cnt_q != STUCK_MAX) begin
      stuck_cnt_d = stuck_cnt_q + STUCK_CW'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      stuck_cnt_q <= '0;
      scl_stuck   <= 1'b0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
      scl_stuck   <= (stuck_cnt_d == STUCK_MAX);
    end
  end
`else
  assign scl_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_line_cond.sv
// Randomised and directed bench for i2c_line_cond against a run-length behavioural model.
`timescale 1ns/1ps
module tb_i2c_line_cond;

  localparam int unsigned FILT_LEN  = 4;
  localparam int unsigned STUCK_CYC = 20;

  logic PCLK      = 1'b0;
  logic PRESETn   = 1'b0;
  logic scl_pad_i = 1'b1;
  logic sda_pad_i = 1'b1;
  logic scl_i, sda_i, start_det, stop_det, bus_busy, scl_stuck;

  i2c_line_cond #(.FILT_LEN(FILT_LEN), .STUCK_CYC(STUCK_CYC)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .scl_pad_i (scl_pad_i),
    .sda_pad_i (sda_pad_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .scl_stuck (scl_stuck)
  );

  always #5 PCLK = ~PCLK;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pads pass a 2-cycle delay; a filtered line flips once the last FILT_LEN
  // delayed samples all disagree with it. Events come from filtered history.
  logic m_sy1 [2];
  logic m_sy2 [2];
  logic m_f   [2];
  logic m_pv  [2];
  logic m_hist[2][16];
  logic m_start, m_stop, m_busy, m_stuck;
  int   m_low_run;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sy1[i] = 1'b1; m_sy2[i] = 1'b1; m_f[i] = 1'b1; m_pv[i] = 1'b1;
      for (int k = 0; k < 16; k++) m_hist[i][k] = 1'b1;
    end
    m_start = 1'b0; m_stop = 1'b0; m_busy = 1'b0; m_stuck = 1'b0; m_low_run = 0;
  endtask

  task automatic model_step();
    logic pad[2];
    logic all_diff;
    pad[0] = scl_pad_i;
    pad[1] = sda_pad_i;
    m_start = m_pv[0] & m_f[0] &  m_pv[1] & ~m_f[1];
    m_stop  = m_pv[0] & m_f[0] & ~m_pv[1] &  m_f[1];
    if (m_start) m_busy = 1'b1;
    else if (m_stop) m_busy = 1'b0;
`ifdef I2C_STUCK_DET_EN
    if (m_f[0]) m_low_run = 0;
    else if (m_low_run < int'(STUCK_CYC)) m_low_run++;
    m_stuck = (m_low_run == int'(STUCK_CYC));
`else
    m_stuck = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      m_pv[i] = m_f[i];
      for (int k = 15; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = m_sy2[i];
      m_sy2[i] = m_sy1[i];
      m_sy1[i] = pad[i];
      all_diff = 1'b1;
      for (int k = 0; k < int'(FILT_LEN); k++)
        if (m_hist[i][k] == m_f[i]) all_diff = 1'b0;
      if (all_diff) m_f[i] = ~m_f[i];
    end
  endtask

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) model_reset();
    else model_step();
  end

  // Compare every cycle and record transition times for the directed checks.
  int   cyc = 0;
  int   start_cnt = 0, stop_cnt = 0, sda_fall_cnt = 0, busy_lo_cnt = 0, stuck_rise_cnt = 0;
  int   scl_fall_cyc = -1000, sda_fall_cyc = -1000, scl_rise_cyc = -1000;
  int   stuck_rise_cyc = -1000, stuck_fall_cyc = -1000;
  logic pr_scl = 1'b1, pr_sda = 1'b1, pr_stuck = 1'b0;

  always @(negedge PCLK) begin
    cyc++;
    chk("scl_i",     scl_i,     m_f[0]);
    chk("sda_i",     sda_i,     m_f[1]);
    chk("start_det", start_det, m_start);
    chk("stop_det",  stop_det,  m_stop);
    chk("bus_busy",  bus_busy,  m_busy);
    chk("scl_stuck", scl_stuck, m_stuck);
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (!bus_busy) busy_lo_cnt++;
    if (pr_scl && !scl_i) scl_fall_cyc = cyc;
    if (!pr_scl && scl_i) scl_rise_cyc = cyc;
    if (pr_sda && !sda_i) begin sda_fall_cyc = cyc; sda_fall_cnt++; end
    if (!pr_stuck && scl_stuck) begin stuck_rise_cyc = cyc; stuck_rise_cnt++; end
    if (pr_stuck && !scl_stuck) stuck_fall_cyc = cyc;
    pr_scl = scl_i; pr_sda = sda_i; pr_stuck = scl_stuck;
  end

  task automatic drive(input logic scl, input logic sda, input int n);
    scl_pad_i = scl;
    sda_pad_i = sda;
    repeat (n) begin @(negedge PCLK); #1; end
  endtask

  int s0, p0, f0, b0, c0, r0;
  logic d;

  initial begin
    repeat (3) begin @(negedge PCLK); #1; end
    chk("rst_scl_i", scl_i, 1);
    chk("rst_sda_i", sda_i, 1);
    chk("rst_start", start_det, 0);
    chk("rst_busy",  bus_busy, 0);
    PRESETn = 1'b1;
    s0 = start_cnt; p0 = stop_cnt; b0 = busy_lo_cnt;
    drive(1, 1, 50);
    chk("idle_start", start_cnt - s0, 0);
    chk("idle_stop",  stop_cnt - p0, 0);
    chk("idle_busy_lo", busy_lo_cnt - b0, 50);

    // 3-cycle SDA glitch is swallowed
    f0 = sda_fall_cnt; s0 = start_cnt;
    drive(1, 0, 3);
    drive(1, 1, 20);
    chk("glitch3_sda_fall", sda_fall_cnt - f0, 0);
    chk("glitch3_start", start_cnt - s0, 0);

    // 4-cycle SDA pulse passes after 2+FILT_LEN cycles and is a START
    c0 = cyc;
    drive(1, 0, 4);
    drive(1, 1, 2);
    chk("pulse4_latency", sda_fall_cyc - c0, 6);
    chk("pulse4_sda_i", sda_i, 0);
    drive(1, 1, 1);
    chk("pulse4_start", start_det, 1);
    chk("pulse4_busy", bus_busy, 1);
    drive(1, 1, 20);

    // Full transaction with repeated START
    s0 = start_cnt; p0 = stop_cnt;
    drive(1, 0, 12);
    drive(0, 0, 8);
    b0 = busy_lo_cnt;
    for (int b = 0; b < 9; b++) begin
      d = 1'($urandom_range(0, 1));
      drive(0, d, 4);
      drive(1, d, 8);
      drive(0, d, 4);
    end
    drive(0, 1, 8);
    drive(1, 1, 8);
    drive(1, 0, 12);
    drive(0, 0, 8);
    drive(1, 0, 6);
    chk("txn_busy_held", busy_lo_cnt - b0, 0);
    drive(1, 1, 12);
    chk("txn_starts", start_cnt - s0, 2);
    chk("txn_stops",  stop_cnt - p0, 1);
    chk("txn_busy_end", bus_busy, 0);

    // Simultaneous fall from idle is not a START
    s0 = start_cnt; c0 = cyc;
    drive(0, 0, 12);
    chk("simul_scl_lat", scl_fall_cyc - c0, 6);
    chk("simul_sda_lat", sda_fall_cyc - c0, 6);
    chk("simul_start", start_cnt - s0, 0);
    chk("simul_busy", bus_busy, 0);
    drive(0, 1, 8);
    drive(1, 1, 12);

    // SCL held low
    r0 = stuck_rise_cnt;
    drive(0, 1, 30);
`ifdef I2C_STUCK_DET_EN
    chk("stuck_rise_dly", stuck_rise_cyc - scl_fall_cyc, int'(STUCK_CYC));
    chk("stuck_held", scl_stuck, 1);
`else
    chk("stuck_off", stuck_rise_cnt - r0, 0);
`endif
    drive(1, 1, 12);
`ifdef I2C_STUCK_DET_EN
    chk("stuck_clear_dly", stuck_fall_cyc - scl_rise_cyc, 1);
`endif
    chk("stuck_after", scl_stuck, 0);

    // Random pad activity
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(1, 8)));
    end
    drive(1, 1, 12);

    // Async reset while busy with pads low
    drive(1, 0, 12);
    drive(0, 0, 10);
    chk("prerst_busy", bus_busy, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_scl_i", scl_i, 1);
    chk("arst_sda_i", sda_i, 1);
    chk("arst_start", start_det, 0);
    chk("arst_stop",  stop_det, 0);
    chk("arst_busy",  bus_busy, 0);
    chk("arst_stuck", scl_stuck, 0);
    drive(0, 0, 2);
    s0 = start_cnt; c0 = cyc;
    PRESETn = 1'b1;
    drive(0, 0, 12);
    chk("post_rst_scl_lat", scl_fall_cyc - c0, 6);
    chk("post_rst_sda_lat", sda_fall_cyc - c0, 6);
    chk("post_rst_start", start_cnt - s0, 0);
    chk("post_rst_busy", bus_busy, 0);
    drive(1, 1, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
